// File: rtl/trace_collector.sv
// Multi-core commit-trace collector: per-core staging, round-robin merge into a show-ahead FIFO, valid/ready drain.
// Optional feature: define TRACE_NOP_FILTER_EN to ignore commits whose instruction word is all zero.
module trace_collector #(
    parameter int NCORES = 2,
    parameter int DEPTH  = 16,
    parameter int CIDW   = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NCORES-1:0]    wb_enable,
    input  logic [NCORES*32-1:0] pc,
    input  logic [NCORES*32-1:0] instr,
    input  logic [NCORES*32-1:0] reg_dat,
    input  logic [NCORES*32-1:0] dat_addr,
    input  logic [NCORES-1:0]    halt,
    output logic                 trace_valid,
    input  logic                 trace_ready,
    output logic [CIDW-1:0]      trace_core,
    output logic [31:0]          trace_seq,
    output logic [31:0]          trace_pc,
    output logic [31:0]          trace_instr,
    output logic [31:0]          trace_dat,
    output logic [31:0]          trace_addr,
    output logic [NCORES*16-1:0] drop_count,
    output logic                 trace_done
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] dat;
        logic [31:0] addr;
    } stage_t;

    typedef struct packed {
        logic [CIDW-1:0] core;
        logic [31:0]     seq;
        stage_t          rec;
    } entry_t;

    stage_t            stage_q [NCORES];
    logic [NCORES-1:0] full_q;
    logic [15:0]       drop_q [NCORES];
    logic [NCORES-1:0] haltSeen_q;
    entry_t            mem_q [DEPTH];
    logic [AW:0]       wptr_q;
    logic [AW:0]       rptr_q;
    logic [31:0]       seq_q;
    logic [CIDW-1:0]   lastGrant_q;

    logic [NCORES-1:0] commit;
    logic [NCORES-1:0] grantVec;
    logic [CIDW-1:0]   grantId;
    logic [CIDW-1:0]   cand;
    logic              grantValid;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              pop;
    entry_t            pushEntry_d;
    entry_t            head;
    int                arbIdx;

    always_comb begin
        for (int k = 0; k < NCORES; k++) begin
`ifdef TRACE_NOP_FILTER_EN
            commit[k] = wb_enable[k] && (instr[32*k +: 32] != 32'h0);
`else
            commit[k] = wb_enable[k];
`endif
        end
    end

    assign fifoEmpty = (wptr_q == rptr_q);
    assign fifoFull  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop       = !fifoEmpty && trace_ready;

    // Round-robin search starting just after the last granted core; a pop frees a slot this cycle.
    always_comb begin
        grantVec   = '0;
        grantId    = '0;
        grantValid = 1'b0;
        arbIdx     = 0;
        cand       = '0;
        if (!fifoFull || pop) begin
            for (int i = 1; i <= NCORES; i++) begin
                arbIdx = int'(lastGrant_q) + i;
                if (arbIdx >= NCORES) arbIdx = arbIdx - NCORES;
                cand = CIDW'(arbIdx);
                if (!grantValid && full_q[cand]) begin
                    grantValid = 1'b1;
                    grantId    = cand;
                end
            end
        end
        if (grantValid) grantVec[grantId] = 1'b1;
    end

    always_comb begin
        pushEntry_d.core = grantId;
        pushEntry_d.seq  = seq_q;
        pushEntry_d.rec  = stage_q[grantId];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            for (int k = 0; k < NCORES; k++) begin
                stage_q[k] <= '0;
                drop_q[k]  <= '0;
            end
            full_q      <= '0;
            haltSeen_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            seq_q       <= '0;
            lastGrant_q <= CIDW'(NCORES - 1);
        end else begin
            if (pop) rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
            if (grantValid) begin
                mem_q[wptr_q[AW-1:0]] <= pushEntry_d;
                wptr_q      <= wptr_q + {{AW{1'b0}}, 1'b1};
                seq_q       <= seq_q + 32'd1;
                lastGrant_q <= grantId;
            end
            // A core being granted this cycle can accept a new record in the same edge.
            for (int k = 0; k < NCORES; k++) begin
                if (commit[k]) begin
                    if (!full_q[k] || grantVec[k]) begin
                        stage_q[k] <= '{pc:    pc[32*k +: 32],
                                        instr: instr[32*k +: 32],
                                        dat:   reg_dat[32*k +: 32],
                                        addr:  dat_addr[32*k +: 32]};
                        full_q[k]  <= 1'b1;
                    end else if (drop_q[k] != 16'hFFFF) begin
                        drop_q[k] <= drop_q[k] + 16'd1;
                    end
                end else if (grantVec[k]) begin
                    full_q[k] <= 1'b0;
                end
            end
            haltSeen_q <= haltSeen_q | halt;
        end
    end

    assign head        = mem_q[rptr_q[AW-1:0]];
    assign trace_valid = !fifoEmpty;
    assign trace_core  = head.core;
    assign trace_seq   = head.seq;
    assign trace_pc    = head.rec.pc;
    assign trace_instr = head.rec.instr;
    assign trace_dat   = head.rec.dat;
    assign trace_addr  = head.rec.addr;
    assign trace_done  = (&haltSeen_q) && !(|full_q) && fifoEmpty;

    always_comb begin
        for (int k = 0; k < NCORES; k++) drop_count[16*k +: 16] = drop_q[k];
    end

endmodule
